ahb_apb_bridge_p: RTL and testbench
===================================

# ahb_apb_bridge_p

Parametrised AHB-Lite slave to APB master bridge, successor to the fixed 32-bit, 4-slave bridge top. It adds configurable data width, address width and slave count, and supports APB wait states (Pready). It maps Pslverr onto a two-cycle AHB ERROR response, generates byte strobes, and enforces a programmable access timeout. It sits between the AHB interconnect and the APB peripheral cluster as a single synthesisable block.

## Interface
- ADDR_W, 32, address width (Haddr, Paddr)
- DATA_W, 32, data width; legal values 8/16/32/64
- NSLV, 4, number of APB slaves (1..16)
- SLV_AW, 12, log2 of each slave's window size in bytes
- BASE_ADDR, 32'h8000_0000, bridge region base; aligned to NSLV·2^SLV_AW
- TIMEOUT, 0, maximum ACCESS cycles before error; 0 disables the timeout

Ports:
- Hclk  in  1  clock
- Hresetn  in  1  reset, asynchronous, active-low
- Htrans  in  2  AHB transfer type
- Hsize  in  3  AHB transfer size
- Hready_in  in  1  bus ready from interconnect
- Hwrite  in  1  write (1) / read (0)
- Haddr  in  ADDR_W  address
- Hwdata  in  DATA_W  write data (data phase)
- Hrdata  out  DATA_W  read data
- Hresp  out  2  response; 2'b00 OKAY, 2'b01 ERROR
- Hready_out  out  1  bridge ready
- Psel  out  NSLV  one-hot slave select
- Penable  out  1  APB access phase
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pstrb  out  DATA_W/8  write byte strobes
- Prdata  in  DATA_W  APB read data (shared, muxed externally)
- Pready  in  1  APB ready
- Pslverr  in  1  APB error

## Operation
- Region hit: Haddr[ADDR_W-1:SLV_AW+SEL_W] equals BASE_ADDR in those same bits. SEL_W = max(1, clog2(NSLV)).
- Slave index: Haddr[SLV_AW +: SEL_W].
- Accept condition: Hready_in && Hready_out && Htrans ∈ {NONSEQ, SEQ} && region hit. IDLE/BUSY transfers and region misses are ignored: Hready_out=1, Hresp=OKAY.
- On accept, latch Haddr, Hwrite, Hsize and the index.
- Bad transfer (index ≥ NSLV, or Hsize > log2(DATA_W/8)): go to ERR1 with no APB activity.
- States:
  - IDLE
  - WDATA: writes only; captures Hwdata into the Pwdata register.
  - SETUP: Psel[idx]=1, Penable=0.
  - ACCESS: Psel[idx]=1, Penable=1.
  - ERR1, ERR2
- Transitions:
  - IDLE → WDATA (write) or SETUP (read).
  - WDATA → SETUP.
  - SETUP → ACCESS.
  - ACCESS holds while Pready=0.
  - ACCESS with Pready=1 && Pslverr=0: transfer completes. If a new transfer is accepted in the same cycle, go directly to WDATA/SETUP; otherwise go to IDLE.
  - ACCESS with Pready=1 && Pslverr=1: go to ERR1.
  - Timeout: ACCESS counter reaches TIMEOUT with Pready=0 → drop Psel/Penable, go to ERR1.
  - ERR1 → ERR2.
  - ERR2 → IDLE, or to WDATA/SETUP if a transfer is accepted in ERR2.
- Pstrb: little-endian lane mask of width 2^Hsize, placed at Haddr[log2(DATA_W/8)-1:0] aligned to the size. Pstrb is all-zero for reads.
- Hrdata = Prdata while in ACCESS with Pready=1. Otherwise Hrdata holds the last registered value.

## Timing
- Reset values:
  - state IDLE
  - Hready_out=1, Hresp=00
  - Psel=0, Penable=0, Pwrite=0
  - Paddr=0, Pwdata=0, Pstrb=0, Hrdata=0
  - timeout counter=0
- Reset asserted mid-transfer aborts immediately: APB outputs drop asynchronously and no response is owed.
- Hready_out per state:
  - IDLE: 1
  - WDATA, SETUP, ERR1: 0
  - ACCESS: Pready && !Pslverr
  - ERR2: 1
- Hresp=ERROR in ERR1 and ERR2; OKAY in all other states.
- Zero-wait latency, address phase at T:
  - Read: SETUP T+1, ACCESS T+2, Hready_out=1 in T+2.
  - Write: WDATA T+1, SETUP T+2, ACCESS T+3.
- Paddr, Pwrite, Pstrb and Pwdata are stable from SETUP through the end of ACCESS.
- APB outputs are registered. Hready_out and Hrdata in ACCESS are combinational from Pready/Prdata.
- Timeout counter clears on entry to SETUP and increments each ACCESS cycle. With TIMEOUT=N, an ACCESS lasting N cycles without Pready errors at the end of cycle N.
- Pready and a timeout expiring in the same cycle: Pready wins.

## Structure
- Shared package ahb_apb_pkg holds:
  - Htrans encodings (IDLE/BUSY/NONSEQ/SEQ)
  - Hresp encodings
  - bridge state enum
  - function for strobe generation
- One sub-module, ahb_apb_decode: combinational region hit, slave index, one-hot select and bad-transfer flag.
- FSM, registers and timeout counter live in ahb_apb_bridge_p.

## Test plan
- Read slave 2, zero wait: Haddr=BASE+0x2004, Prdata=0xDEADBEEF, Pready=1. Expect Psel=4'b0100, ACCESS at T+2, Hrdata=0xDEADBEEF with Hready_out=1 and Hresp=OKAY.
- Byte write: Haddr=BASE+0x1003, Hsize=0, Hwdata=0xAB000000, two Pready=0 cycles. Expect Pstrb=4'b1000 and Pwdata=0xAB000000 held stable, Hready_out low until the third ACCESS cycle.
- Pslverr=1 on read → Hresp=01 for two cycles, Hready_out 0 then 1.
- NSLV=3, access to index 3 → ERR1/ERR2 with Psel never asserted.
- TIMEOUT=4, Pready stuck at 0 → after 4 ACCESS cycles Psel drops and the ERROR response follows.
- Back-to-back read then write: the NONSEQ presented in the completing ACCESS cycle goes straight to WDATA with no IDLE gap.
- Hresetn asserted during ACCESS → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared types and helpers for the AHB-Lite to APB bridge.
// Holds the bus encodings, the bridge state enum and byte-strobe generation.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

    // Little-endian lane mask of 2^size bytes, aligned to the size within a
    // bus word of strb_w bytes (strb_w <= 8). Callers truncate to strb_w.
    function automatic logic [7:0] strb_gen(
        input logic [2:0]  size,
        input logic [2:0]  addr_lo,
        input int unsigned strb_w
    );
        int unsigned n_bytes;
        int unsigned offset;
        logic [15:0] mask;
        n_bytes = 32'd1 << size;
        offset  = 32'(addr_lo) & (strb_w - 1) & ~(n_bytes - 1);
        mask    = 16'((32'd1 << n_bytes) - 1) << offset;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/ahb_apb_decode.sv
// Combinational address decode: region hit, one-hot slave select and the
// bad-transfer flag (slave index out of range or size wider than the bus).
module ahb_apb_decode
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NSLV      = 4,
    parameter int                SLV_AW    = 12,
    parameter int                SEL_W     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000)
)(
    input  logic [ADDR_W-1:SLV_AW] i_haddr_hi,
    input  logic [2:0]             i_hsize,
    output logic                   o_hit,
    output logic [NSLV-1:0]        o_sel,
    output logic                   o_bad
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam int TAG_LSB  = SLV_AW + SEL_W;

    logic [SEL_W-1:0] w_idx;

    assign o_hit = (i_haddr_hi[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
    assign w_idx = i_haddr_hi[SLV_AW +: SEL_W];
    assign o_bad = (32'(w_idx) >= NSLV) || (32'(i_hsize) > MAX_SIZE);

    // NOTE: defaulting every always_comb output first keeps the block free of latches.
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            o_sel[i] = (32'(w_idx) == i);
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// Parametrised AHB-Lite slave to APB master bridge with wait states, slave
// error mapping, byte strobes and an optional ACCESS-phase timeout.
module ahb_apb_bridge_p
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NSLV      = 4,
    parameter int                SLV_AW    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int                TIMEOUT   = 0
)(
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic [1:0]            Htrans,
    input  logic [2:0]            Hsize,
    input  logic                  Hready_in,
    input  logic                  Hwrite,
    input  logic [ADDR_W-1:0]     Haddr,
    input  logic [DATA_W-1:0]     Hwdata,
    output logic [DATA_W-1:0]     Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hready_out,
    output logic [NSLV-1:0]       Psel,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_W-1:0]     Paddr,
    output logic [DATA_W-1:0]     Pwdata,
    output logic [DATA_W/8-1:0]   Pstrb,
    input  logic [DATA_W-1:0]     Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr
);

    localparam int SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    bridge_state_t     r_state;
    bridge_state_t     w_next;
    bridge_state_t     w_start;

    logic              w_hit;
    logic              w_bad;
    logic [NSLV-1:0]   w_sel;
    logic [NSLV-1:0]   w_sel_src;
    logic [STRB_W-1:0] w_strb;
    logic              w_hready;
    logic              w_accept;
    logic              w_tmo;

    logic [NSLV-1:0]   r_sel;
    logic [NSLV-1:0]   r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [STRB_W-1:0] r_pstrb;
    logic [DATA_W-1:0] r_hrdata;
    logic [CNT_W-1:0]  r_cnt;

    ahb_apb_decode #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NSLV      (NSLV),
        .SLV_AW    (SLV_AW),
        .SEL_W     (SEL_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .i_haddr_hi (Haddr[ADDR_W-1:SLV_AW]),
        .i_hsize    (Hsize),
        .o_hit      (w_hit),
        .o_sel      (w_sel),
        .o_bad      (w_bad)
    );

    always_comb begin
        w_hready = 1'b0;
        case (r_state)
            ST_IDLE:   w_hready = 1'b1;
            ST_ACCESS: w_hready = Pready && !Pslverr;
            ST_ERR2:   w_hready = 1'b1;
            default:   w_hready = 1'b0;
        endcase
    end

    assign w_accept  = Hready_in && w_hready && w_hit &&
                       (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);
    assign w_start   = w_bad ? ST_ERR1 : (Hwrite ? ST_WDATA : ST_SETUP);
    assign w_tmo     = (TIMEOUT != 0) && (32'(r_cnt) == 32'(TIMEOUT - 1));
    assign w_sel_src = w_accept ? w_sel : r_sel;
    assign w_strb    = STRB_W'(strb_gen(Hsize, Haddr[2:0], STRB_W));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = w_start;
            ST_WDATA:  w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: begin
                if (Pready) begin
                    if (Pslverr)       w_next = ST_ERR1;
                    else if (w_accept) w_next = w_start;
                    else               w_next = ST_IDLE;
                end else if (w_tmo) begin
                    w_next = ST_ERR1;
                end
            end
            ST_ERR1:   w_next = ST_ERR2;
            ST_ERR2:   w_next = w_accept ? w_start : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_sel     <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_hrdata  <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_sel    <= w_sel;
                r_paddr  <= Haddr;
                r_pwrite <= Hwrite;
                r_pstrb  <= (Hwrite && !w_bad) ? w_strb : '0;
            end
            if (r_state == ST_WDATA) r_pwdata <= Hwdata;

            // Select and enable are registered from the next state so APB sees clean edges.
            r_psel    <= (w_next == ST_SETUP || w_next == ST_ACCESS) ? w_sel_src : '0;
            r_penable <= (w_next == ST_ACCESS);

            if (w_next == ST_SETUP)       r_cnt <= '0;
            else if (r_state == ST_ACCESS) r_cnt <= r_cnt + CNT_W'(1);

            if (r_state == ST_ACCESS && Pready) r_hrdata <= Prdata;
        end
    end

    assign Psel       = r_psel;
    assign Penable    = r_penable;
    assign Pwrite     = r_pwrite;
    assign Paddr      = r_paddr;
    assign Pwdata     = r_pwdata;
    assign Pstrb      = r_pstrb;
    assign Hready_out = w_hready;
    assign Hresp      = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign Hrdata     = (r_state == ST_ACCESS && Pready) ? Prdata : r_hrdata;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Directed bench for ahb_apb_bridge_p: a default instance (4 slaves, no
// timeout) and a 3-slave instance with TIMEOUT=4 share the bus stimulus.
module tb_ahb_apb_bridge_p;
    import ahb_apb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  htrans_a, htrans_b;
    logic [2:0]  hsize;
    logic        hready_in;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic [31:0] a_hrdata, b_hrdata;
    logic [1:0]  a_hresp, b_hresp;
    logic        a_hready, b_hready;
    logic [3:0]  a_psel;
    logic [2:0]  b_psel;
    logic        a_penable, b_penable;
    logic        a_pwrite, b_pwrite;
    logic [31:0] a_paddr, b_paddr;
    logic [31:0] a_pwdata, b_pwdata;
    logic [3:0]  a_pstrb, b_pstrb;

    int n_assert = 0;
    int n_fail   = 0;

    ahb_apb_bridge_p u_dut_a (
        .Hclk       (clk),
        .Hresetn    (rst_n),
        .Htrans     (htrans_a),
        .Hsize      (hsize),
        .Hready_in  (hready_in),
        .Hwrite     (hwrite),
        .Haddr      (haddr),
        .Hwdata     (hwdata),
        .Hrdata     (a_hrdata),
        .Hresp      (a_hresp),
        .Hready_out (a_hready),
        .Psel       (a_psel),
        .Penable    (a_penable),
        .Pwrite     (a_pwrite),
        .Paddr      (a_paddr),
        .Pwdata     (a_pwdata),
        .Pstrb      (a_pstrb),
        .Prdata     (prdata),
        .Pready     (pready),
        .Pslverr    (pslverr)
    );

    ahb_apb_bridge_p #(
        .NSLV    (3),
        .TIMEOUT (4)
    ) u_dut_b (
        .Hclk       (clk),
        .Hresetn    (rst_n),
        .Htrans     (htrans_b),
        .Hsize      (hsize),
        .Hready_in  (hready_in),
        .Hwrite     (hwrite),
        .Haddr      (haddr),
        .Hwdata     (hwdata),
        .Hrdata     (b_hrdata),
        .Hresp      (b_hresp),
        .Hready_out (b_hready),
        .Psel       (b_psel),
        .Penable    (b_penable),
        .Pwrite     (b_pwrite),
        .Paddr      (b_paddr),
        .Pwdata     (b_pwdata),
        .Pstrb      (b_pstrb),
        .Prdata     (prdata),
        .Pready     (pready),
        .Pslverr    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        htrans_a  = HTRANS_IDLE;
        htrans_b  = HTRANS_IDLE;
        hsize     = 3'd0;
        hwrite    = 1'b0;
        haddr     = '0;
        hwdata    = '0;
        hready_in = 1'b1;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        #12 rst_n = 1'b1;

        to_mid();
        check("rst_hready", a_hready, 1);
        check("rst_hresp", a_hresp, 0);
        check("rst_psel", a_psel, 0);
        check("rst_penable", a_penable, 0);
        check("rst_paddr", a_paddr, 0);
        check("rst_hrdata", a_hrdata, 0);
        check("rst_pstrb", a_pstrb, 0);

        // Zero-wait read of slave 2
        to_next();
        haddr = 32'h8000_2004; hwrite = 1'b0; hsize = 3'd2;
        htrans_a = HTRANS_NONSEQ; pready = 1'b1; prdata = 32'hDEAD_BEEF;
        to_mid();
        check("t1_addr_ready", a_hready, 1);
        to_next(); htrans_a = HTRANS_IDLE;
        to_mid();
        check("t1_setup_psel", a_psel, 4'b0100);
        check("t1_setup_penable", a_penable, 0);
        check("t1_setup_hready", a_hready, 0);
        check("t1_setup_paddr", a_paddr, 32'h8000_2004);
        check("t1_setup_pwrite", a_pwrite, 0);
        to_next();
        to_mid();
        check("t1_acc_penable", a_penable, 1);
        check("t1_acc_psel", a_psel, 4'b0100);
        check("t1_acc_hready", a_hready, 1);
        check("t1_acc_hresp", a_hresp, 0);
        check("t1_acc_hrdata", a_hrdata, 32'hDEAD_BEEF);
        to_next(); prdata = '0;
        to_mid();
        check("t1_idle_psel", a_psel, 0);
        check("t1_hrdata_held", a_hrdata, 32'hDEAD_BEEF);

        // Region miss is ignored
        to_next(); haddr = 32'h4000_2000; htrans_a = HTRANS_NONSEQ;
        to_next(); htrans_a = HTRANS_IDLE;
        to_mid();
        check("miss_psel", a_psel, 0);
        check("miss_hready", a_hready, 1);

        // Byte write to slave 1 lane 3 with two wait states
        to_next();
        haddr = 32'h8000_1003; hwrite = 1'b1; hsize = 3'd0;
        htrans_a = HTRANS_NONSEQ; pready = 1'b0;
        to_next(); htrans_a = HTRANS_IDLE; hwdata = 32'hAB00_0000;
        to_mid();
        check("t2_wdata_hready", a_hready, 0);
        check("t2_wdata_psel", a_psel, 0);
        to_next(); hwdata = '0;
        to_mid();
        check("t2_setup_psel", a_psel, 4'b0010);
        check("t2_setup_penable", a_penable, 0);
        check("t2_setup_pwrite", a_pwrite, 1);
        check("t2_setup_pstrb", a_pstrb, 4'b1000);
        check("t2_setup_pwdata", a_pwdata, 32'hAB00_0000);
        to_next();
        to_mid();
        check("t2_acc1_penable", a_penable, 1);
        check("t2_acc1_hready", a_hready, 0);
        to_next();
        to_mid();
        check("t2_acc2_hready", a_hready, 0);
        check("t2_acc2_pstrb", a_pstrb, 4'b1000);
        check("t2_acc2_pwdata", a_pwdata, 32'hAB00_0000);
        to_next(); pready = 1'b1;
        to_mid();
        check("t2_acc3_hready", a_hready, 1);
        check("t2_acc3_penable", a_penable, 1);
        check("t2_acc3_pstrb", a_pstrb, 4'b1000);
        check("t2_acc3_pwdata", a_pwdata, 32'hAB00_0000);
        check("t2_acc3_hresp", a_hresp, 0);
        to_next();
        to_mid();
        check("t2_done_psel", a_psel, 0);

        // Slave error on a read of slave 0
        to_next();
        haddr = 32'h8000_0010; hwrite = 1'b0; hsize = 3'd2;
        htrans_a = HTRANS_NONSEQ; pready = 1'b1; pslverr = 1'b1;
        to_next(); htrans_a = HTRANS_IDLE;
        to_next();
        to_mid();
        check("t3_acc_hready", a_hready, 0);
        check("t3_acc_hresp", a_hresp, 0);
        to_next(); pslverr = 1'b0;
        to_mid();
        check("t3_err1_hresp", a_hresp, 2'b01);
        check("t3_err1_hready", a_hready, 0);
        check("t3_err1_psel", a_psel, 0);
        check("t3_err1_penable", a_penable, 0);
        to_next();
        to_mid();
        check("t3_err2_hresp", a_hresp, 2'b01);
        check("t3_err2_hready", a_hready, 1);
        to_next();
        to_mid();
        check("t3_idle_hresp", a_hresp, 0);

        // Oversized transfer (doubleword on a 32-bit bus)
        to_next();
        haddr = 32'h8000_0000; hwrite = 1'b1; hsize = 3'd3; htrans_a = HTRANS_NONSEQ;
        to_next(); htrans_a = HTRANS_IDLE; hsize = 3'd2;
        to_mid();
        check("size_err1_hresp", a_hresp, 2'b01);
        check("size_err1_hready", a_hready, 0);
        check("size_err1_psel", a_psel, 0);
        to_next();
        to_mid();
        check("size_err2_hresp", a_hresp, 2'b01);
        check("size_err2_hready", a_hready, 1);
        check("size_err2_psel", a_psel, 0);

        // NSLV=3: index 3 is out of range
        to_next();
        haddr = 32'h8000_3000; hwrite = 1'b0; hsize = 3'd2; htrans_b = HTRANS_NONSEQ;
        to_mid();
        check("t4_addr_hready", b_hready, 1);
        to_next(); htrans_b = HTRANS_IDLE;
        to_mid();
        check("t4_err1_hresp", b_hresp, 2'b01);
        check("t4_err1_hready", b_hready, 0);
        check("t4_err1_psel", b_psel, 0);
        to_next();
        to_mid();
        check("t4_err2_hresp", b_hresp, 2'b01);
        check("t4_err2_hready", b_hready, 1);
        check("t4_err2_psel", b_psel, 0);
        to_next();
        to_mid();
        check("t4_idle_hresp", b_hresp, 0);

        // TIMEOUT=4 with Pready stuck low
        to_next();
        haddr = 32'h8000_1000; hwrite = 1'b0; hsize = 3'd2;
        htrans_b = HTRANS_NONSEQ; pready = 1'b0;
        to_next(); htrans_b = HTRANS_IDLE;
        to_mid();
        check("t5_setup_psel", b_psel, 3'b010);
        for (int i = 1; i <= 4; i++) begin
            to_next();
            to_mid();
            check($sformatf("t5_acc%0d_penable", i), b_penable, 1);
            check($sformatf("t5_acc%0d_hready", i), b_hready, 0);
        end
        to_next();
        to_mid();
        check("t5_err1_psel", b_psel, 0);
        check("t5_err1_penable", b_penable, 0);
        check("t5_err1_hresp", b_hresp, 2'b01);
        check("t5_err1_hready", b_hready, 0);
        to_next();
        to_mid();
        check("t5_err2_hresp", b_hresp, 2'b01);
        check("t5_err2_hready", b_hready, 1);

        // Back-to-back read then write with no IDLE gap
        to_next();
        haddr = 32'h8000_0000; hwrite = 1'b0; hsize = 3'd2;
        htrans_a = HTRANS_NONSEQ; pready = 1'b1; prdata = 32'h1234_5678;
        to_next(); htrans_a = HTRANS_IDLE;
        to_next();
        haddr = 32'h8000_3000; hwrite = 1'b1; hsize = 3'd2; htrans_a = HTRANS_NONSEQ;
        to_mid();
        check("t6_rd_hready", a_hready, 1);
        check("t6_rd_hrdata", a_hrdata, 32'h1234_5678);
        check("t6_rd_pwrite", a_pwrite, 0);
        to_next(); htrans_a = HTRANS_IDLE; hwdata = 32'hCAFE_F00D;
        to_mid();
        check("t6_wdata_hready", a_hready, 0);
        check("t6_wdata_psel", a_psel, 0);
        to_next(); hwdata = '0;
        to_mid();
        check("t6_setup_psel", a_psel, 4'b1000);
        check("t6_setup_paddr", a_paddr, 32'h8000_3000);
        check("t6_setup_pwrite", a_pwrite, 1);
        check("t6_setup_pstrb", a_pstrb, 4'b1111);
        check("t6_setup_pwdata", a_pwdata, 32'hCAFE_F00D);
        to_next();
        to_mid();
        check("t6_acc_hready", a_hready, 1);
        check("t6_acc_penable", a_penable, 1);

        // Asynchronous reset in the middle of ACCESS
        to_next();
        haddr = 32'h8000_2000; hwrite = 1'b0; hsize = 3'd2;
        htrans_a = HTRANS_NONSEQ; pready = 1'b0;
        to_next(); htrans_a = HTRANS_IDLE;
        to_next();
        to_mid();
        check("t7_acc_penable", a_penable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_psel", a_psel, 0);
        check("t7_rst_penable", a_penable, 0);
        check("t7_rst_paddr", a_paddr, 0);
        check("t7_rst_pwdata", a_pwdata, 0);
        check("t7_rst_pwrite", a_pwrite, 0);
        check("t7_rst_hrdata", a_hrdata, 0);
        check("t7_rst_hready", a_hready, 1);
        check("t7_rst_hresp", a_hresp, 0);
        #1 rst_n = 1'b1;
        pready = 1'b1;
        to_next();
        to_mid();
        check("t7_after_psel", a_psel, 0);
        check("t7_after_hready", a_hready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
